// File: rtl/tetris_pkg.sv
// Shared board geometry, cell/color types and address helpers for the Tetris playfield store.
package tetris_pkg;

    localparam int BOARD_W = 21;
    localparam int BOARD_H = 41;
    localparam int ADDR_W  = 10;

    typedef logic [4:0]        cell_x_t;
    typedef logic [5:0]        cell_y_t;
    typedef logic [3:0]        color_t;
    typedef logic [ADDR_W-1:0] cell_idx_t;

    localparam color_t    WHITE      = 4'd7;
    localparam color_t    WALL_COLOR = 4'd8;
    localparam cell_idx_t CELL_LAST  = cell_idx_t'(BOARD_W * BOARD_H - 1);

    // Where a pending read result comes from when it lands the next cycle.
    typedef enum logic [1:0] {
        SRC_RAM   = 2'd0,
        SRC_WHITE = 2'd1,
        SRC_WALL  = 2'd2
    } rd_src_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } clr_state_t;

    // Row-major linear cell index; only meaningful for in-range coordinates.
    function automatic cell_idx_t cell_idx(input cell_x_t x, input cell_y_t y);
        return cell_idx_t'(y) * cell_idx_t'(BOARD_W) + cell_idx_t'(x);
    endfunction

    // Wrapped coordinates (e.g. x = 31 after moving left from 0) fall outside too.
    function automatic logic in_range(input cell_x_t x, input cell_y_t y);
        return (int'(x) < BOARD_W) && (int'(y) < BOARD_H);
    endfunction

endpackage

// File: rtl/tetris_board_mem_if.sv
// Control, display and clear signals between the game logic and the board store.
interface tetris_board_mem_if;
    import tetris_pkg::*;

    logic        sram_we;
    logic        sram_re;
    cell_x_t     curr_x;
    cell_y_t     curr_y;
    logic [2:0]  color_w;
    color_t      sram_color;
    logic        disp_re;
    cell_x_t     disp_x;
    cell_y_t     disp_y;
    color_t      disp_color;
    logic        disp_valid;
    logic        clear_req;
    logic        busy;

    modport master (
        output sram_we, sram_re, curr_x, curr_y, color_w,
        output disp_re, disp_x, disp_y, clear_req,
        input  sram_color, disp_color, disp_valid, busy
    );

    modport slave (
        input  sram_we, sram_re, curr_x, curr_y, color_w,
        input  disp_re, disp_x, disp_y, clear_req,
        output sram_color, disp_color, disp_valid, busy
    );

endinterface

// File: rtl/tetris_board_ram.sv
// Single-port 1024x4 synchronous RAM, write-first: a write returns its own data next cycle.
module tetris_board_ram
    import tetris_pkg::*;
(
    input  logic      clk,
    input  logic      we_i,
    input  cell_idx_t addr_i,
    input  color_t    wdata_i,
    output color_t    rdata_o
);

    color_t mem_q [1 << ADDR_W];
    color_t rdata_q;

    // One access per cycle; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_q       <= wdata_i;
        end else begin
            rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tetris_board_mem.sv
// Board store: arbitrates control/display/clear onto one RAM port, range-checks, runs the clear sweep.
module tetris_board_mem
    import tetris_pkg::*;
(
    input logic                clk,
    input logic                reset,
    tetris_board_mem_if.slave  bus
);

    clr_state_t state_q, state_d;
    cell_idx_t  cnt_q, cnt_d;

    logic      busy;
    logic      ctrl_act, ctrl_in, disp_in, disp_grant;
    logic      ram_we;
    cell_idx_t ram_addr;
    color_t    ram_wdata, ram_rdata;

    logic      ctrl_pend_q, disp_pend_q;
    rd_src_t   ctrl_src_d, ctrl_src_q, disp_src_d, disp_src_q;
    color_t    ctrl_hold_q, disp_hold_q;
    color_t    ctrl_val, disp_val;

    assign busy       = (state_q == S_CLEAR);
    assign ctrl_act   = bus.sram_we | bus.sram_re;
    assign ctrl_in    = in_range(bus.curr_x, bus.curr_y);
    assign disp_in    = in_range(bus.disp_x, bus.disp_y);
    // While clearing, display reads never touch the RAM, so they are always granted.
    assign disp_grant = bus.disp_re & (busy | ~ctrl_act);

    // Clear sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear sequencer next state: one cell per cycle, 0..CELL_LAST, then back to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.clear_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CELL_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // RAM port mux: clear sweep, then control, then display.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = cell_idx(bus.disp_x, bus.disp_y);
        ram_wdata = {1'b0, bus.color_w};
        if (busy) begin
            ram_we    = ~reset;
            ram_addr  = cnt_q;
            ram_wdata = WHITE;
        end else if (ctrl_act) begin
            ram_we    = bus.sram_we & ctrl_in & ~reset;
            ram_addr  = cell_idx(bus.curr_x, bus.curr_y);
        end
    end

    // Pick the source each accepted read will be answered from next cycle.
    always_comb begin
        ctrl_src_d = SRC_RAM;
        disp_src_d = SRC_RAM;
        if (busy) begin
            ctrl_src_d = SRC_WHITE;
            disp_src_d = SRC_WHITE;
        end else begin
            if (!ctrl_in) ctrl_src_d = SRC_WALL;
            if (!disp_in) disp_src_d = SRC_WALL;
        end
    end

    // Pending-read flags and held output values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_pend_q <= 1'b0;
            disp_pend_q <= 1'b0;
            ctrl_src_q  <= SRC_RAM;
            disp_src_q  <= SRC_RAM;
            ctrl_hold_q <= '0;
            disp_hold_q <= '0;
        end else begin
            ctrl_pend_q <= bus.sram_re;
            disp_pend_q <= disp_grant;
            if (bus.sram_re) ctrl_src_q <= ctrl_src_d;
            if (disp_grant)  disp_src_q <= disp_src_d;
            if (ctrl_pend_q) ctrl_hold_q <= ctrl_val;
            if (disp_pend_q) disp_hold_q <= disp_val;
        end
    end

    // Resolve the landing read data from its recorded source.
    always_comb begin
        ctrl_val = ram_rdata;
        disp_val = ram_rdata;
        case (ctrl_src_q)
            SRC_WHITE: ctrl_val = WHITE;
            SRC_WALL:  ctrl_val = WALL_COLOR;
            default:   ctrl_val = ram_rdata;
        endcase
        case (disp_src_q)
            SRC_WHITE: disp_val = WHITE;
            SRC_WALL:  disp_val = WALL_COLOR;
            default:   disp_val = ram_rdata;
        endcase
    end

    assign bus.sram_color = ctrl_pend_q ? ctrl_val : ctrl_hold_q;
    assign bus.disp_color = disp_pend_q ? disp_val : disp_hold_q;
    assign bus.disp_valid = disp_pend_q;
    assign bus.busy       = busy;

    tetris_board_ram u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_tetris_board_mem.sv
// Bench for tetris_board_mem: directed vector table, clear/reset sequences, random traffic vs a board model.
module tb_tetris_board_mem;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    tetris_board_mem_if bus ();

    tetris_board_mem dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain board array plus expected held outputs.
    int board [861];
    int clr_left;
    int e_sc, e_dv, e_dc;

    typedef struct {
        logic we; logic re; int x; int y; int cw;
        logic dre; int dx; int dy;
        int sc; int dv; int dc;
    } vec_t;

    vec_t tbl [14];

    function automatic bit inr(input int x, input int y);
        return (x < 21) && (y < 41);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model by the same cycle, compare after the edge.
    task automatic step(input logic we, input logic re, input int x, input int y, input int cw,
                        input logic dre, input int dx, input int dy,
                        input logic creq, input logic rst);
        bit busy_now;
        bus.sram_we   = we;
        bus.sram_re   = re;
        bus.curr_x    = x[4:0];
        bus.curr_y    = y[5:0];
        bus.color_w   = cw[2:0];
        bus.disp_re   = dre;
        bus.disp_x    = dx[4:0];
        bus.disp_y    = dy[5:0];
        bus.clear_req = creq;
        reset         = rst;
        if (rst) begin
            clr_left = 0; e_sc = 0; e_dv = 0; e_dc = 0;
        end else begin
            busy_now = (clr_left > 0);
            e_dv = 0;
            if (busy_now) begin
                board[861 - clr_left] = 7;
                clr_left--;
                if (re) e_sc = 7;
                if (dre) begin e_dv = 1; e_dc = 7; end
            end else begin
                if (we && inr(x, y)) board[y*21 + x] = cw & 7;
                if (re) e_sc = inr(x, y) ? board[y*21 + x] : 8;
                if (dre && !we && !re) begin
                    e_dv = 1;
                    e_dc = inr(dx, dy) ? board[dy*21 + dx] : 8;
                end
                if (creq) clr_left = 861;
            end
        end
        @(posedge clk);
        #1;
        check("sram_color", int'(bus.sram_color), e_sc);
        check("disp_valid", int'(bus.disp_valid), e_dv);
        check("disp_color", int'(bus.disp_color), e_dc);
        check("busy",       int'(bus.busy),       (clr_left > 0) ? 1 : 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int cnt;
        tests = 0; fails = 0;
        clr_left = 0; e_sc = 0; e_dv = 0; e_dc = 0;
        foreach (board[i]) board[i] = 0;
        bus.sram_we = 0; bus.sram_re = 0; bus.curr_x = 0; bus.curr_y = 0; bus.color_w = 0;
        bus.disp_re = 0; bus.disp_x = 0; bus.disp_y = 0; bus.clear_req = 0;
        reset = 1;

        // Reset state.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();

        // Init sweep so every cell has a known value: (idx % 5) + 1.
        for (int y = 0; y < 41; y++)
            for (int x = 0; x < 21; x++)
                step(1, 0, x, y, ((y*21 + x) % 5) + 1, 0, 0, 0, 0, 0);

        // Directed vectors: {we, re, x, y, cw, dre, dx, dy, sc, dv, dc}.
        tbl[0]  = '{1'b1, 1'b0,  3, 10, 5, 1'b0,  0,  0, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b1,  3, 10, 0, 1'b0,  0,  0, 5, 0, 0};
        tbl[2]  = '{1'b0, 1'b0,  0,  0, 0, 1'b0,  0,  0, 5, 0, 0};
        tbl[3]  = '{1'b0, 1'b0,  0,  0, 0, 1'b0,  0,  0, 5, 0, 0};
        tbl[4]  = '{1'b0, 1'b0,  0,  0, 0, 1'b0,  0,  0, 5, 0, 0};
        tbl[5]  = '{1'b0, 1'b1, 31,  0, 0, 1'b0,  0,  0, 8, 0, 0};
        tbl[6]  = '{1'b1, 1'b0,  0, 41, 2, 1'b0,  0,  0, 8, 0, 0};
        tbl[7]  = '{1'b0, 1'b1,  0, 40, 0, 1'b0,  0,  0, 1, 0, 0};
        tbl[8]  = '{1'b0, 1'b1,  3, 10, 0, 1'b1,  3, 10, 5, 0, 0};
        tbl[9]  = '{1'b0, 1'b0,  0,  0, 0, 1'b1,  3, 10, 5, 1, 5};
        tbl[10] = '{1'b0, 1'b0,  0,  0, 0, 1'b0,  0,  0, 5, 0, 5};
        tbl[11] = '{1'b1, 1'b1, 20, 40, 6, 1'b0,  0,  0, 6, 0, 5};
        tbl[12] = '{1'b0, 1'b0,  0,  0, 0, 1'b1, 20, 40, 6, 1, 6};
        tbl[13] = '{1'b0, 1'b0,  0,  0, 0, 1'b1, 31,  0, 6, 1, 8};
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].we, tbl[i].re, tbl[i].x, tbl[i].y, tbl[i].cw,
                 tbl[i].dre, tbl[i].dx, tbl[i].dy, 0, 0);
            check($sformatf("vec%0d_sc", i), int'(bus.sram_color), tbl[i].sc);
            check($sformatf("vec%0d_dv", i), int'(bus.disp_valid), tbl[i].dv);
            check($sformatf("vec%0d_dc", i), int'(bus.disp_color), tbl[i].dc);
        end

        // Random traffic, including wrapped/out-of-range coordinates.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 31), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 40),
                 $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 31), $urandom_range(0, 63), 0, 0);
        end

        // Full clear: length, ignored re-request, dropped write, reads during busy.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cnt = bus.busy ? 1 : 0;
        while (bus.busy && cnt < 2000) begin
            if (cnt == 100)      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            else if (cnt == 200) step(1, 0, 5, 5, 3, 0, 0, 0, 0, 0);
            else if (cnt == 300) step(0, 1, 20, 40, 0, 1, 3, 10, 0, 0);
            else if (cnt == 301) step(1, 1, 31, 0, 2, 1, 31, 0, 0, 0);
            else                 idle();
            if (bus.busy) cnt++;
        end
        check("busy_len", cnt, 861);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("clr_0_0", int'(bus.sram_color), 7);
        step(0, 1, 20, 40, 0, 0, 0, 0, 0, 0);
        check("clr_20_40", int'(bus.sram_color), 7);
        step(0, 1, 3, 10, 0, 0, 0, 0, 0, 0);
        check("clr_3_10", int'(bus.sram_color), 7);
        step(0, 1, 5, 5, 0, 0, 0, 0, 0, 0);
        check("clr_dropped_wr", int'(bus.sram_color), 7);

        // Reset mid-clear: idx 800 = (2,38) set first, idx 10 = (10,0) gets cleared.
        step(1, 0, 2, 38, 4, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i < 50; i++) begin
            if (i == 40)      step(0, 1, 2, 38, 0, 0, 0, 0, 0, 0);
            else if (i == 49) step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
            else              idle();
        end
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_sc", int'(bus.sram_color), 0);
        check("rst_dv", int'(bus.disp_valid), 0);
        step(0, 1, 10, 0, 0, 0, 0, 0, 0, 0);
        check("rst_idx10", int'(bus.sram_color), 7);
        step(0, 1, 2, 38, 0, 0, 0, 0, 0, 0);
        check("rst_idx800", int'(bus.sram_color), 4);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tetris_board_mem.md
Name: tetris_board_mem

Overview:
Board storage and responder for the Tetris playfield. It holds one 4-bit color per cell of the 21x41 board. It serves the control FSM's cell read/write port (sram_we/sram_re/curr_x/curr_y/color_w -> sram_color) and a secondary display read port. It also provides a hardware clear sequencer that fills the board with white. The block sits between the game control FSM and the VGA color mapper, and wraps a single-port synchronous RAM.

Parameters:
BOARD_W, 21, board columns (x range 0..BOARD_W-1)
BOARD_H, 41, board rows (y range 0..BOARD_H-1)
WHITE, 4'd7, empty-cell color written by clear
WALL_COLOR, 4'd8, color returned for out-of-range reads

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sram_we  in  1  control write strobe, one cell per cycle
sram_re  in  1  control read strobe
curr_x  in  5  control cell x
curr_y  in  6  control cell y
color_w  in  3  control write color, zero-extended to 4 bits
sram_color  out  4  control read data, valid the cycle after sram_re, held until the next control read
disp_re  in  1  display read request
disp_x  in  5  display cell x
disp_y  in  6  display cell y
disp_color  out  4  display read data
disp_valid  out  1  pulses 1 cycle after a granted disp_re
clear_req  in  1  pulse: start full-board clear
busy  out  1  high while the clear sequencer runs

Behaviour:
- Address: idx = y*BOARD_W + x, 10 bits, range 0..860. RAM is 1024x4. Indices 861..1023 are unused.
- Range check: x >= BOARD_W or y >= BOARD_H is out of range. This includes the wrapped x = 31 produced by a left move from x = 0.
  - An out-of-range read returns WALL_COLOR with the normal 1-cycle latency.
  - An out-of-range write is dropped; RAM is unchanged.
- Control port has absolute priority over the display port.
- Read latency: sram_re in cycle N gives sram_color in cycle N+1. sram_color holds its value until the next sram_re.
- Simultaneous sram_we and sram_re: the write is performed, and sram_color in N+1 equals the written color (write-first).
- Display arbitration: a disp_re in the same cycle as sram_we or sram_re is not granted. disp_valid stays 0 in N+1 and the requester retries. A granted disp_re gives disp_valid = 1 and disp_color in N+1. disp_color holds between grants.
- Clear FSM states:
  - IDLE: on clear_req go to CLEAR, cnt = 0, busy = 1.
  - CLEAR: write WHITE at cnt each cycle, cnt += 1. At cnt == 860, write and go to IDLE. busy drops the following cycle.
  - A clear therefore takes exactly 861 cycles with busy high.
- While busy:
  - control writes are dropped;
  - control reads return WHITE at normal latency;
  - display reads are always granted and return WHITE without a RAM access.
- clear_req while busy is ignored; the sequence does not restart.
- Reset values: sram_color = 0, disp_color = 0, disp_valid = 0, busy = 0, state IDLE, cnt = 0. RAM contents are not reset; the controller's init sweep or clear_req defines them.
- Reset mid-clear aborts immediately: busy = 0 next cycle, board partially cleared.

Decomposition:
- tetris_pkg holds:
  - BOARD_W, BOARD_H, WHITE, WALL_COLOR;
  - cell_x_t (5b), cell_y_t (6b), color_t (4b);
  - a cell_idx function (y*BOARD_W + x);
  - an in_range function.
- Sub-module tetris_board_ram: single-port 1024x4 synchronous RAM with we, addr[9:0], wdata[3:0], rdata[3:0] (write-first). The top level does arbitration, range checking and clear sequencing.

Test Plan:
- Write/read: sram_we x = 3, y = 10, color_w = 5; then sram_re at (3,10) -> sram_color = 4'd5 one cycle later, held through 3 idle cycles.
- Out-of-range:
  - sram_re at x = 31, y = 0 -> sram_color = 4'd8;
  - sram_we at x = 0, y = 41, color 2, then read (0,40) -> the prior value is unchanged.
- Arbitration: disp_re at (3,10) in the same cycle as sram_re -> disp_valid = 0 next cycle; repeat disp_re alone -> disp_valid = 1, disp_color = 4'd5.
- Write-first: sram_we and sram_re together at (20,40), color 6 -> sram_color = 4'd6 next cycle.
- Clear:
  - clear_req -> busy high exactly 861 cycles;
  - a second clear_req at cycle 100 is ignored;
  - a sram_we during busy is dropped;
  - after busy falls, read (0,0), (20,40), (3,10) -> 4'd7.
- Reset mid-clear: reset at clear cycle 50 -> busy = 0, sram_color = 0, disp_valid = 0 next cycle; cell idx 10 = 7; cell idx 800 retains its pre-clear value.
